// File: rtl/uart_tx_frame_pkg.sv
// Shared definitions for the UART transmit framer: FSM states,
// parity selection codes and the line levels of the framing bits.
package uart_tx_frame_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    localparam logic PAR_EVEN  = 1'b0;
    localparam logic PAR_ODD   = 1'b1;
    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

endpackage

// File: rtl/uart_tx_serializer.sv
// Data shift register (LSB out first) plus the data-bit counter that
// tells the framer when the last data bit is on its way out.
module uart_tx_serializer #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [DATA_WIDTH-1:0] data,
    input  logic                  shift,
    input  logic                  clr_cnt,
    input  logic                  inc_cnt,
    output logic                  bit_out,
    output logic                  last
);

    localparam int CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    logic [DATA_WIDTH-1:0] sreg;
    logic [CW-1:0]         cnt;

    // load wins over shift so a frame accepted during STOP starts clean
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            sreg <= '0;
        else if (load)
            sreg <= data;
        else if (shift)
            sreg <= {1'b0, sreg[DATA_WIDTH-1:1]};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt <= '0;
        else if (clr_cnt)
            cnt <= '0;
        else if (inc_cnt && !last)
            cnt <= cnt + 1'b1;
    end

    assign bit_out = sreg[0];
    assign last    = (cnt == CW'(DATA_WIDTH - 1));

endmodule

// File: rtl/uart_tx_frame.sv
// UART transmit framer: start bit, DATA_WIDTH data bits LSB first,
// optional parity bit, stop bit; one bit per CLK with registered outputs.
module uart_tx_frame
    import uart_tx_frame_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] P_DATA,
    input  logic                  Data_Valid,
    input  logic                  parity_enable,
    input  logic                  parity_type,
    output logic                  TX_OUT,
    output logic                  Busy
);

    state_t state, state_nx;
    logic   accept;
    logic   par_en, par_bit;
    logic   tx_nx, busy_nx, shift;
    logic   ser_bit, ser_last;

    assign accept = Data_Valid && (state == IDLE || state == STOP);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state   <= IDLE;
            par_en  <= 1'b0;
            par_bit <= 1'b0;
        end else begin
            state <= state_nx;
            if (accept) begin
                par_en  <= parity_enable;
                par_bit <= (parity_type == PAR_ODD) ? ~(^P_DATA) : ^P_DATA;
            end
        end
    end

    // Outputs are registered from the next state so the line is glitch-free
    // and the start bit appears in the cycle right after acceptance.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            TX_OUT <= STOP_BIT;
            Busy   <= 1'b0;
        end else begin
            TX_OUT <= tx_nx;
            Busy   <= busy_nx;
        end
    end

    always_comb begin
        state_nx = state;
        tx_nx    = STOP_BIT;
        busy_nx  = 1'b0;
        shift    = 1'b0;
        case (state)
            IDLE, STOP: if (accept) state_nx = START;
                        else        state_nx = IDLE;
            START:      state_nx = DATA;
            DATA:       if (ser_last) state_nx = par_en ? PARITY : STOP;
            PARITY:     state_nx = STOP;
            default:    state_nx = IDLE;
        endcase
        case (state_nx)
            START: begin
                tx_nx   = START_BIT;
                busy_nx = 1'b1;
            end
            DATA: begin
                tx_nx   = ser_bit;
                busy_nx = 1'b1;
                shift   = 1'b1;
            end
            PARITY: begin
                tx_nx   = par_bit;
                busy_nx = 1'b1;
            end
            default: ;
        endcase
    end

    uart_tx_serializer #(.DATA_WIDTH(DATA_WIDTH)) u_ser (
        .clk     (CLK),
        .rst     (RST),
        .load    (accept),
        .data    (P_DATA),
        .shift   (shift),
        .clr_cnt (state == START),
        .inc_cnt (state == DATA),
        .bit_out (ser_bit),
        .last    (ser_last)
    );

endmodule
